// File: rtl/reset_sequencer_if.sv
// Handshake bundle for reset_sequencer: soft-reset requests and watchdog kick
// in, staged enables and status out. clk/rst stay plain ports on the design.
interface reset_sequencer_if #(
  parameter int NSTAGE = 4
);
  logic [NSTAGE-1:0] soft_req;
  logic              kick;
  logic [NSTAGE-1:0] en;
  logic [NSTAGE-1:0] ack;
  logic              busy;
  logic              done;
  logic              wdt_fired;

  // Requester / observer side
  modport master (
    output soft_req, kick,
    input  en, ack, busy, done, wdt_fired
  );

  // Sequencer side
  modport slave (
    input  soft_req, kick,
    output en, ack, busy, done, wdt_fired
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: releases NSTAGE enables one every STAGE_DLY clocks,
// serves one soft-reset request at a time (lowest index wins) with a
// HOLD_CLK-clock all-low hold, then re-sequences from stage 0.
// Optional watchdog is compiled in with the RSTSEQ_WDT_EN macro; without it
// kick is ignored and wdt_fired is tied low.
module reset_sequencer #(
  parameter int NSTAGE    = 4,
  parameter int STAGE_DLY = 62,
  parameter int HOLD_CLK  = 16,
  parameter int WDT_LIM   = 1000
) (
  input logic               clk,
  input logic               rst,
  reset_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_SEQ  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [7:0] STAGE_LAST = 8'(STAGE_DLY - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CLK - 1);
  localparam logic [2:0] LAST_IDX   = 3'(NSTAGE - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        seq_cnt_q, seq_cnt_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [NSTAGE-1:0] en_q, en_d;
  logic [NSTAGE-1:0] ack_q, ack_d;
  // Low for the first un-reset edge so en[k] lands exactly (k+1)*STAGE_DLY
  // edges after reset release, matching the timing used after a HOLD exit.
  logic              arm_q;

  logic [NSTAGE-1:0] stage_sel;
  logic [NSTAGE-1:0] req_win;

  // One-hot decode of the stage currently being released
  generate
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage_sel
      assign stage_sel[gi] = (idx_q == 3'(gi));
    end
  endgenerate

  // Isolate the lowest set request bit; ack can therefore never be multi-hot
  assign req_win = bus.soft_req & (~bus.soft_req + NSTAGE'(1));

`ifdef RSTSEQ_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(WDT_LIM - 1);
  logic [15:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_fired_q, wdt_fired_d;
`else
  logic unused_kick;
  assign unused_kick = bus.kick;
`endif

  // Next-state logic for the SEQ / RUN / HOLD sequencer
  always_comb begin
    state_d    = state_q;
    seq_cnt_d  = seq_cnt_q;
    hold_cnt_d = hold_cnt_q;
    idx_d      = idx_q;
    en_d       = en_q;
    ack_d      = '0;
`ifdef RSTSEQ_WDT_EN
    wdt_cnt_d   = '0;
    wdt_fired_d = wdt_fired_q;
`endif
    case (state_q)
      ST_SEQ: begin
        if (arm_q) begin
          if (seq_cnt_q == STAGE_LAST) begin
            en_d      = en_q | stage_sel;
            seq_cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = ST_RUN;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            seq_cnt_d = seq_cnt_q + 8'd1;
          end
        end
      end
      ST_RUN: begin
        if (|bus.soft_req) begin
          // A soft request always beats a coincident watchdog expiry
          ack_d      = req_win;
          en_d       = '0;
          hold_cnt_d = '0;
          state_d    = ST_HOLD;
        end
`ifdef RSTSEQ_WDT_EN
        else if (bus.kick) begin
          wdt_cnt_d = '0;
        end else if (wdt_cnt_q == WDT_LAST) begin
          en_d        = '0;
          wdt_fired_d = 1'b1;
          hold_cnt_d  = '0;
          state_d     = ST_HOLD;
        end else begin
          wdt_cnt_d = wdt_cnt_q + 16'd1;
        end
`endif
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          seq_cnt_d  = '0;
          idx_d      = '0;
          state_d    = ST_SEQ;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        en_d       = '0;
        seq_cnt_d  = '0;
        hold_cnt_d = '0;
        idx_d      = '0;
        state_d    = ST_SEQ;
      end
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEQ;
      seq_cnt_q  <= '0;
      hold_cnt_q <= '0;
      idx_q      <= '0;
      en_q       <= '0;
      ack_q      <= '0;
      arm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_cnt_q  <= seq_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      idx_q      <= idx_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
      arm_q      <= 1'b1;
    end
  end

`ifdef RSTSEQ_WDT_EN
  // Watchdog counter and sticky expiry flag; only rst clears the flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end
  assign bus.wdt_fired = wdt_fired_q;
`else
  assign bus.wdt_fired = 1'b0;
`endif

  // Status derived straight from the enable register so it never lags en
  assign bus.en   = en_q;
  assign bus.ack  = ack_q;
  assign bus.done = &en_q;
  assign bus.busy = ~(&en_q);

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameters SHALL be: NSTAGE, 4, number of staged enables (1..8); STAGE_DLY, 62, clocks per stage (1..255); HOLD_CLK, 16, clocks all enables held low after a soft reset (1..255); WDT_LIM, 1000, watchdog timeout in clocks (1..65535).
REQ-002 clk  input  1  system clock, 40 MHz; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 soft_req  input  NSTAGE  level soft-reset requests, one per requester; a requester drops its bit after its ack.
REQ-005 kick  input  1  watchdog refresh pulse.
REQ-006 en  output  NSTAGE  staged subsystem enables; en[0] is released first.
REQ-007 ack  output  NSTAGE  one-cycle acceptance pulse per requester.
REQ-008 busy  output  1  high while any enable is low (sequencing or hold).
REQ-009 done  output  1  high when all en bits are high.
REQ-010 wdt_fired  output  1  sticky watchdog-expiry flag.

Function
REQ-011 The FSM SHALL have exactly these states: SEQ (releasing stages), RUN (all enabled), HOLD (soft-reset hold).
REQ-012 SEQ: an 8-bit counter SHALL count clocks; when count equals STAGE_DLY-1, en[idx] SHALL rise at the next edge, the counter SHALL clear and idx SHALL increment.
REQ-013 en[k] SHALL rise exactly (k+1)*STAGE_DLY clocks after the first rising edge at which rst is low.
REQ-014 Once set, en bits SHALL NOT fall in SEQ; after en[NSTAGE-1] rises the FSM SHALL enter RUN on the same edge.
REQ-015 done SHALL equal &en and busy SHALL equal ~done; both SHALL be registered-consistent with en (no extra cycle of lag).
REQ-016 RUN: when any soft_req bit is high at an edge, the lowest set index i SHALL win; ack[i] SHALL be high for exactly the next cycle, all en SHALL be low in that same cycle, and the FSM SHALL enter HOLD.
REQ-017 Simultaneous requests: only the lowest index SHALL be acked; other requesters remain un-acked and are served on a later RUN entry if still asserted.
REQ-018 soft_req SHALL be ignored (no ack, no effect) in SEQ and HOLD.
REQ-019 HOLD: all en SHALL stay low for exactly HOLD_CLK clocks; then the FSM SHALL enter SEQ with idx=0 and counter cleared, re-applying REQ-013 timing from HOLD exit.
REQ-020 ack SHALL never have more than one bit set.

Reset
REQ-021 While rst is high: en=0, ack=0, busy=1, done=0, wdt_fired=0, FSM=SEQ, idx=0, all counters=0.
REQ-022 rst asserted in any state, including mid-SEQ or mid-HOLD, SHALL take effect at the next edge and restart sequencing from stage 0 when released.

Configuration
REQ-023 Macro RSTSEQ_WDT_EN: when defined, a 16-bit watchdog counter SHALL run only in RUN, clear on kick or on leaving RUN, and on reaching WDT_LIM-1 without kick SHALL drop all en at the next edge, set wdt_fired, and enter HOLD (no ack).
REQ-024 Watchdog expiry and a soft_req at the same edge: the soft request SHALL win (ack issued) and wdt_fired SHALL NOT set.
REQ-025 When RSTSEQ_WDT_EN is undefined: no watchdog logic, kick ignored, wdt_fired tied 0; ports remain present.
REQ-026 wdt_fired SHALL clear only on rst.

Verification
REQ-027 Power-up with defaults: rst high 5 clocks then low -> en[0] at clock 62, en[1] at 124, en[2] at 186, en[3] at 248; done rises at 248.
REQ-028 In RUN, soft_req=4'b0110 -> ack=4'b0010 for one cycle, en=0 for 16 clocks, then en[0] rises 62 clocks after HOLD exit; bit 2 request re-served after next RUN entry if still held.
REQ-029 soft_req=4'b0001 asserted during SEQ at clock 100 and dropped at 150 -> no ack, sequencing timing unchanged.
REQ-030 rst pulsed high for 1 clock at clock 130 (en=4'b0011) -> en=0 next cycle; en[0] rises 62 clocks after rst falls.
REQ-031 With RSTSEQ_WDT_EN, WDT_LIM=100, no kick in RUN -> en drop 100 clocks after RUN entry, wdt_fired=1 and stays 1 through re-sequencing; kick every 50 clocks -> no expiry.
REQ-032 Without RSTSEQ_WDT_EN, no kick for 70000 clocks in RUN -> en stays 4'b1111, wdt_fired=0.
